// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up the system PLL and the fabric reset behind it. Pulses the PLL
//   reset, waits for lock with a timeout and a bounded number of retries,
//   requires lock to hold for a qualification interval, then releases the
//   system reset. Loss of lock while running re-asserts system reset and
//   restarts the sequence.
//
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN
//   Defined   -> adds loss_cnt[7:0], a saturating count of lock-loss events.
//   Undefined -> no loss_cnt port or logic.
//
// Ports
//   refclk       in   free-running sequencer clock
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock indicator (asynchronous to refclk)
//   restart      in   1-cycle pulse, restart the sequence from PLL reset
//   clr_lost     in   1-cycle pulse, clear the lock_lost sticky bit
//   pll_rst_out  out  reset to the PLL
//   sys_rst_out  out  active-high system reset
//   ready        out  high only while running
//   fail         out  high only after retries are exhausted
//   lock_lost    out  sticky, lock dropped while running
//   retry_cnt    out  attempts consumed in the current sequence
//   loss_cnt     out  (optional) lock-loss events, saturating at 255
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    input  logic       clr_lost,
    output logic       pll_rst_out,
    output logic       sys_rst_out,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
`ifdef PLL_SEQ_LOSS_COUNT_EN
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
`else
    output logic [3:0] retry_cnt
`endif
);

    localparam int CNT_M1  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_M1 > STABLE_CYCLES) ? CNT_M1 : STABLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    retry_n;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic          loss_evt;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge refclk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], pll_locked};
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        retry_n  = retry_cnt;
        loss_evt = 1'b0;
        if (restart) begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
            retry_n = 4'd0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock
                    if (lock_s) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end else if (cnt == TMO_LAST) begin
                        cnt_n = '0;
                        if (retry_cnt == RETRY_MAX) begin
                            state_n = S_FAIL;
                        end else begin
                            state_n = S_PLL_RST;
                            retry_n = retry_cnt + 4'd1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A dropout during qualification goes back to waiting
                    // without consuming a retry
                    if (!lock_s) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                        retry_n = 4'd0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_n  = S_PLL_RST;
                        cnt_n    = '0;
                        loss_evt = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_n = S_FAIL;
                end
                default: begin
                    state_n = S_PLL_RST;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself (e.g. sys_rst_out rises as RUN is left).
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            retry_cnt   <= 4'd0;
            pll_rst_out <= 1'b1;
            sys_rst_out <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            retry_cnt   <= retry_n;
            pll_rst_out <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
            sys_rst_out <= (state_n != S_RUN);
            ready       <= (state_n == S_RUN);
            fail        <= (state_n == S_FAIL);
            // A new loss beats a coincident clear
            if (loss_evt)      lock_lost <= 1'b1;
            else if (clr_lost) lock_lost <= 1'b0;
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt <= 8'd0;
        end else if (loss_evt) begin
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
        end else if (clr_lost) begin
            loss_cnt <= 8'd0;
        end
    end
`endif

endmodule
